// File: rtl/jtcps1_pkg.sv
// Shared constants and types for the CPS1 line output buffer.
// Used by jtcps1_lineout and jtcps1_linebank.
package jtcps1_pkg;

  localparam int PXLW_DEFAULT = 12;
  localparam int LINE_LATENCY = 2;
  localparam int BANK_DEPTH   = 512;
  localparam int AW           = $clog2(BANK_DEPTH);

  typedef struct packed {
    logic hb;
    logic vb;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_BLANK = '{
    hb: 1'b1,
    vb: 1'b1,
    hs: 1'b0,
    vs: 1'b0
  };

  function automatic logic is_blank(sync_t s);
    return s.hb | s.vb;
  endfunction

endpackage

// File: rtl/jtcps1_linebank.sv
// One 512-entry line bank: synchronous write port,
// asynchronous read port addressed by a registered column.
module jtcps1_linebank
  import jtcps1_pkg::*;
#(
  parameter int DW = PXLW_DEFAULT
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [BANK_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jtcps1_lineout.sv
// Double-buffered line output: one bank scans out while the other fills.
// Define JTCPS1_LINE_ERASE_EN to clear each column after it is scanned.
module jtcps1_lineout
  import jtcps1_pkg::*;
#(
  parameter int PXLW    = PXLW_DEFAULT,
  parameter int LATENCY = LINE_LATENCY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen8,
  input  logic [8:0]      hdump,
  input  logic            start,
  input  logic            HB,
  input  logic            VB,
  input  logic            HS,
  input  logic            VS,
  input  logic [8:0]      wr_addr,
  input  logic [PXLW-1:0] wr_data,
  input  logic            wr_en,
  output logic [PXLW-1:0] pxl,
  output logic            HB_o,
  output logic            VB_o,
  output logic            HS_o,
  output logic            VS_o
);

  logic            rd_bank_q;
  logic [AW-1:0]   rd_addr_q;
  logic [PXLW-1:0] pxl_q;
  logic [PXLW-1:0] pxl_d;
  logic [PXLW-1:0] rdata [2];
  logic            erase;
  sync_t           sync_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_q <= 1'b0;
    end else if (cen8 && start) begin
      rd_bank_q <= ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q <= '0;
    end else if (cen8) begin
      rd_addr_q <= hdump;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        sync_q[i] <= SYNC_BLANK;
      end
    end else if (cen8) begin
      sync_q[0] <= '{hb: HB, vb: VB, hs: HS, vs: VS};
      for (int i = 1; i < LATENCY; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // blanking is judged on the stage that lands with this pixel
  assign pxl_d = is_blank(sync_q[0]) ? '0
               : rdata[rd_bank_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      pxl_q <= '0;
    end else if (cen8) begin
      pxl_q <= pxl_d;
    end
  end

`ifdef JTCPS1_LINE_ERASE_EN
  logic rd_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
    end else if (cen8) begin
      rd_vld_q <= 1'b1;
    end
  end

  assign erase = cen8 && rd_vld_q && !rst;
`else
  assign erase = 1'b0;
`endif

  // read bank owns erase, write bank owns wr_*
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic            is_rd;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [PXLW-1:0] wdata;

    assign is_rd = (rd_bank_q == 1'(b));
    assign we    = is_rd ? erase     : wr_en;
    assign waddr = is_rd ? rd_addr_q : wr_addr;
    assign wdata = is_rd ? '0        : wr_data;

    jtcps1_linebank #(
      .DW (PXLW)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (rd_addr_q),
      .rdata_o (rdata[b])
    );
  end

  assign pxl  = pxl_q;
  assign HB_o = sync_q[LATENCY-1].hb;
  assign VB_o = sync_q[LATENCY-1].vb;
  assign HS_o = sync_q[LATENCY-1].hs;
  assign VS_o = sync_q[LATENCY-1].vs;

endmodule
